// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes combinationally from state and instruction,
// bounds every memory wait, and counts retired instructions.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  state,
    output logic        halted,
    output logic        error,
    output logic [31:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    // SPECIAL functs
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    // ALU operations
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t              r_state;
    state_t              w_state_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [31:0]         r_instr_count;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_special;
    logic       w_add, w_sub, w_and, w_or, w_slt, w_jr, w_sys;
    logic       w_addi, w_addiu, w_sltiu, w_ori;
    logic       w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
    logic       w_r_alu, w_i_alu, w_supported;
    logic       w_wait_expired;
    logic       w_unused_ir;
    logic [2:0] w_alu_op;

    // Pre-reset strobe values; reset masks them at the outputs.
    logic w_ir_write, w_pc_write, w_mem_read, w_mem_write, w_reg_write;

    assign w_op        = instruction[31:26];
    assign w_fn        = instruction[5:0];
    assign w_unused_ir = ^instruction[25:6];

    assign w_special = (w_op == OP_SPECIAL);
    assign w_add     = w_special && (w_fn == FN_ADD);
    assign w_sub     = w_special && (w_fn == FN_SUB);
    assign w_and     = w_special && (w_fn == FN_AND);
    assign w_or      = w_special && (w_fn == FN_OR);
    assign w_slt     = w_special && (w_fn == FN_SLT);
    assign w_jr      = w_special && (w_fn == FN_JR);
    assign w_sys     = w_special && (w_fn == FN_SYSCALL);
    assign w_addi    = (w_op == OP_ADDI);
    assign w_addiu   = (w_op == OP_ADDIU);
    assign w_sltiu   = (w_op == OP_SLTIU);
    assign w_ori     = (w_op == OP_ORI);
    assign w_lw      = (w_op == OP_LW);
    assign w_sw      = (w_op == OP_SW);
    assign w_beq     = (w_op == OP_BEQ);
    assign w_bne     = (w_op == OP_BNE);
    assign w_j       = (w_op == OP_J);
    assign w_jal     = (w_op == OP_JAL);

    assign w_r_alu     = w_add | w_sub | w_and | w_or | w_slt;
    assign w_i_alu     = w_addi | w_addiu | w_sltiu | w_ori;
    assign w_supported = w_r_alu | w_i_alu | w_lw | w_sw | w_beq | w_bne |
                         w_j | w_jal | w_jr | w_sys;

    // Last permitted wait cycle: one more cycle without mem_ready is a timeout.
    assign w_wait_expired = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

    // ALU operation selected by the instruction class.
    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_sub || w_beq || w_bne) begin
            w_alu_op = ALU_SUB;
        end else if (w_and) begin
            w_alu_op = ALU_AND;
        end else if (w_or || w_ori) begin
            w_alu_op = ALU_OR;
        end else if (w_slt || w_sltiu) begin
            w_alu_op = ALU_SLT;
        end
    end

    // Next-state decision and per-state datapath controls.
    always_comb begin
        w_state_next = r_state;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        pc_src       = 2'b00;
        iord         = 1'b0;
        RegDst       = 2'b00;
        MemToReg     = 2'b00;
        ALUSrc       = 1'b0;
        ALUop        = ALU_AND;
        case (r_state)
            ST_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_wait_expired) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (!w_supported) begin
                    w_state_next = ST_ERROR;
                end else if (w_sys) begin
                    w_state_next = ST_HALT;
                end else if (w_j || w_jal) begin
                    w_pc_write   = 1'b1;
                    pc_src       = 2'b10;
                    w_state_next = ST_FETCH;
                    if (w_jal) begin
                        w_reg_write = 1'b1;
                        RegDst      = 2'b10;
                        MemToReg    = 2'b10;
                    end
                end else if (w_jr) begin
                    w_pc_write   = 1'b1;
                    pc_src       = 2'b11;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALUop  = w_alu_op;
                ALUSrc = w_i_alu | w_lw | w_sw;
                if (w_beq || w_bne) begin
                    pc_src       = 2'b01;
                    w_pc_write   = w_beq ? zero : ~zero;
                    w_state_next = ST_FETCH;
                end else if (w_lw || w_sw) begin
                    w_state_next = ST_MEM;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_MEM: begin
                ALUop       = w_alu_op;
                ALUSrc      = w_i_alu | w_lw | w_sw;
                iord        = 1'b1;
                w_mem_read  = w_lw;
                w_mem_write = w_sw;
                if (mem_ready) begin
                    w_state_next = w_lw ? ST_WB : ST_FETCH;
                end else if (w_wait_expired) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_WB: begin
                ALUop        = w_alu_op;
                ALUSrc       = w_i_alu | w_lw | w_sw;
                w_reg_write  = 1'b1;
                RegDst       = w_r_alu ? 2'b01 : 2'b00;
                MemToReg     = w_lw ? 2'b01 : 2'b00;
                w_state_next = ST_FETCH;
            end
            ST_HALT:  w_state_next = ST_HALT;
            ST_ERROR: w_state_next = ST_ERROR;
            default:  w_state_next = ST_ERROR;
        endcase
    end

    // Reset suppresses every write/read strobe in the cycle it is asserted.
    assign ir_write  = w_ir_write  & ~reset;
    assign pc_write  = w_pc_write  & ~reset;
    assign mem_read  = w_mem_read  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign RegWrite  = w_reg_write & ~reset;

    assign state       = r_state;
    assign halted      = (r_state == ST_HALT);
    assign error       = (r_state == ST_ERROR);
    assign instr_count = r_instr_count;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter: counts cycles stalled in FETCH/MEM, cleared on any state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if ((r_state == ST_FETCH || r_state == ST_MEM) && (w_state_next == r_state)) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Retired-instruction counter: one per return to FETCH from an active state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if ((w_state_next == ST_FETCH) &&
                     (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB})) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds the expected state path of each
// instruction from its class and the chosen memory latencies, then checks
// state, control outputs and retired count every cycle.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 16;

    localparam int K_ALU_R = 0;
    localparam int K_ALU_I = 1;
    localparam int K_LW    = 2;
    localparam int K_SW    = 3;
    localparam int K_BR    = 4;
    localparam int K_J     = 5;
    localparam int K_JAL   = 6;
    localparam int K_JR    = 7;
    localparam int K_SYS   = 8;
    localparam int K_ILL   = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        ir_write, pc_write, iord, mem_read, mem_write, RegWrite, ALUSrc;
    logic [1:0]  pc_src, RegDst, MemToReg;
    logic [2:0]  ALUop, state;
    logic        halted, error;
    logic [31:0] instr_count;

    logic [17:0] w_obs;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_count = 32'd0;

    typedef struct {
        int   st;
        logic rdy;
    } step_t;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .ALUop       (ALUop),
        .state       (state),
        .halted      (halted),
        .error       (error),
        .instr_count (instr_count)
    );

    assign w_obs = {ir_write, pc_write, pc_src, iord, mem_read, mem_write,
                    RegDst, MemToReg, RegWrite, ALUSrc, ALUop, halted, error};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction class and ALU operation straight from the opcode tables.
    function automatic void classify(input logic [31:0] ins, output int kind,
                                     output logic [2:0] aop, output logic beq);
        logic [5:0] op;
        logic [5:0] fn;
        op   = ins[31:26];
        fn   = ins[5:0];
        kind = K_ILL;
        aop  = 3'b010;
        beq  = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h20: kind = K_ALU_R;
                6'h22: begin kind = K_ALU_R; aop = 3'b110; end
                6'h24: begin kind = K_ALU_R; aop = 3'b000; end
                6'h25: begin kind = K_ALU_R; aop = 3'b001; end
                6'h2A: begin kind = K_ALU_R; aop = 3'b111; end
                6'h08: kind = K_JR;
                6'h0C: kind = K_SYS;
                default: kind = K_ILL;
            endcase
            6'h08, 6'h09: kind = K_ALU_I;
            6'h0B: begin kind = K_ALU_I; aop = 3'b111; end
            6'h0D: begin kind = K_ALU_I; aop = 3'b001; end
            6'h23: kind = K_LW;
            6'h2B: kind = K_SW;
            6'h04: begin kind = K_BR; aop = 3'b110; beq = 1'b1; end
            6'h05: begin kind = K_BR; aop = 3'b110; end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            default: kind = K_ILL;
        endcase
    endfunction

    // Expected control outputs in a given phase, plus a mask of the bits that matter.
    function automatic void exp_vec(input int st, input int kind, input logic [2:0] aop,
                                    input logic beq, input logic rdy, input logic z,
                                    output logic [17:0] e, output logic [17:0] m);
        logic       ir, pw, io, mr, mw, rw, as, h, er;
        logic [1:0] ps, rd, m2r;
        logic [2:0] op;
        {ir, pw, io, mr, mw, rw, as, h, er} = '0;
        ps = 2'b00; rd = 2'b00; m2r = 2'b00; op = 3'b000;
        if (st >= 2 && st <= 4) begin
            op = aop;
            as = (kind == K_ALU_I) || (kind == K_LW) || (kind == K_SW);
        end
        case (st)
            0: begin mr = 1'b1; ir = rdy; pw = rdy; end
            1: begin
                if (kind == K_J || kind == K_JAL) begin pw = 1'b1; ps = 2'b10; end
                if (kind == K_JAL) begin rw = 1'b1; rd = 2'b10; m2r = 2'b10; end
                if (kind == K_JR) begin pw = 1'b1; ps = 2'b11; end
            end
            2: if (kind == K_BR) begin ps = 2'b01; pw = beq ? z : ~z; end
            3: begin io = 1'b1; mr = (kind == K_LW); mw = (kind == K_SW); end
            4: begin
                rw  = 1'b1;
                rd  = (kind == K_ALU_R) ? 2'b01 : 2'b00;
                m2r = (kind == K_LW) ? 2'b01 : 2'b00;
            end
            5: h = 1'b1;
            6: er = 1'b1;
            default: ;
        endcase
        e = {ir, pw, ps, io, mr, mw, rd, m2r, rw, as, op, h, er};
        m = '1;
        if (!(st >= 2 && st <= 4)) m[5:2] = 4'b0;
        if (!rw) m[10:7] = 4'b0;
        if (!(pw || (st == 2 && kind == K_BR))) m[15:14] = 2'b0;
        if (!(st == 0 || st == 3)) m[13] = 1'b0;
    endfunction

    // Called just after a falling edge; leaves the DUT in FETCH after release.
    task automatic do_reset();
        reset       = 1'b1;
        mem_ready   = 1'b1;
        instruction = $urandom;
        #1;
        check("reset strobes", 32'({ir_write, pc_write, mem_read, mem_write, RegWrite}), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        model_count = 32'd0;
        check("reset state", 32'(state), 32'd0);
        check("reset count", instr_count, model_count);
        check("reset flags", 32'({halted, error}), 32'd0);
    endtask

    // fw/mw: stall cycles before mem_ready in FETCH/MEM (>= MEM_TIMEOUT means timeout).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        step_t       q[$];
        int          kind;
        logic [2:0]  aop;
        logic        beq;
        int          fin;
        logic [17:0] e, m;
        classify(ins, kind, aop, beq);
        fin = -1;
        for (int i = 0; i <= fw; i++) begin
            if (i == MEM_TIMEOUT) begin fin = 6; break; end
            q.push_back('{st: 0, rdy: (i == fw)});
        end
        if (fin < 0) begin
            q.push_back('{st: 1, rdy: 1'($urandom)});
            case (kind)
                K_ILL: fin = 6;
                K_SYS: fin = 5;
                K_J, K_JAL, K_JR: fin = 0;
                K_BR: begin q.push_back('{st: 2, rdy: 1'($urandom)}); fin = 0; end
                K_ALU_R, K_ALU_I: begin
                    q.push_back('{st: 2, rdy: 1'($urandom)});
                    q.push_back('{st: 4, rdy: 1'($urandom)});
                    fin = 0;
                end
                default: begin
                    q.push_back('{st: 2, rdy: 1'($urandom)});
                    for (int i = 0; i <= mw; i++) begin
                        if (i == MEM_TIMEOUT) begin fin = 6; break; end
                        q.push_back('{st: 3, rdy: (i == mw)});
                    end
                    if (fin < 0) begin
                        if (kind == K_LW) q.push_back('{st: 4, rdy: 1'($urandom)});
                        fin = 0;
                    end
                end
            endcase
        end
        if (fin == 0) model_count = model_count + 32'd1;
        foreach (q[k]) begin
            instruction = ins;
            zero        = (q[k].st == 2) ? z : 1'($urandom);
            mem_ready   = q[k].rdy;
            #1;
            check($sformatf("state %08h step %0d", ins, k), 32'(state), 32'(q[k].st));
            exp_vec(q[k].st, kind, aop, beq, q[k].rdy, zero, e, m);
            check($sformatf("outputs %08h st%0d", ins, q[k].st), 32'(w_obs & m), 32'(e & m));
            @(negedge clk);
        end
        instruction = ins;
        mem_ready   = (fin == 0) ? 1'b0 : 1'b1;
        #1;
        check($sformatf("end state %08h", ins), 32'(state), 32'(fin));
        check($sformatf("instr_count %08h", ins), instr_count, model_count);
        if (fin != 0) begin
            exp_vec(fin, kind, aop, beq, 1'b1, zero, e, m);
            check("absorbing outputs", 32'(w_obs & m), 32'(e & m));
            @(negedge clk);
            #1;
            check("absorbing state", 32'(state), 32'(fin));
            check("absorbing count", instr_count, model_count);
            do_reset();
        end
    endtask

    function automatic int rnd_wait();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(14, 17));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 15))
            0: ins[31:26] = 6'h08;
            1: ins[31:26] = 6'h09;
            2: ins[31:26] = 6'h0B;
            3: ins[31:26] = 6'h0D;
            4: ins[31:26] = 6'h23;
            5: ins[31:26] = 6'h2B;
            6: ins[31:26] = 6'h04;
            7: ins[31:26] = 6'h05;
            8: ins[31:26] = 6'h02;
            9: ins[31:26] = 6'h03;
            10, 11, 12: begin
                ins[31:26] = 6'h00;
                case ($urandom_range(0, 6))
                    0: ins[5:0] = 6'h20;
                    1: ins[5:0] = 6'h22;
                    2: ins[5:0] = 6'h24;
                    3: ins[5:0] = 6'h25;
                    4: ins[5:0] = 6'h2A;
                    5: ins[5:0] = 6'h08;
                    default: ins[5:0] = 6'h0C;
                endcase
            end
            13: ins[31:26] = 6'h00;
            default: ;
        endcase
        return ins;
    endfunction

    // Directed scenarios first, then a randomized instruction stream.
    initial begin
        reset       = 1'b1;
        instruction = 32'd0;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        run_instr(32'h000A4820, 0, 0, 1'b0);     // ADD, count becomes 1
        run_instr(32'h8C880004, 0, 3, 1'b0);     // LW with 3 stalled MEM cycles
        run_instr(32'h10850010, 1, 0, 1'b1);     // BEQ taken
        run_instr(32'h10850010, 0, 0, 1'b0);     // BEQ not taken
        run_instr(32'h14850010, 0, 0, 1'b0);     // BNE taken
        run_instr(32'h000A4820, 16, 0, 1'b0);    // FETCH timeout -> ERROR
        run_instr(32'h000A4820, 15, 0, 1'b0);    // ready on last allowed cycle
        run_instr(32'hFC000000, 0, 0, 1'b0);     // illegal opcode -> ERROR
        run_instr(32'h000A4820, 0, 0, 1'b0);
        run_instr(32'h0000000C, 0, 0, 1'b0);     // SYSCALL -> HALT, count held
        run_instr(32'hAC850008, 0, 16, 1'b0);    // SW MEM timeout -> ERROR
        run_instr(32'h8C880004, 2, 15, 1'b0);    // LW ready on last allowed MEM cycle
        run_instr(32'h0C000040, 0, 0, 1'b0);     // JAL
        run_instr(32'h03E00008, 0, 0, 1'b0);     // JR
        run_instr(32'h3508FFFF, 0, 0, 1'b0);     // ORI

        // Reset while a SW is in MEM: write strobe must drop and count clear.
        instruction = 32'hAC850008;
        mem_ready   = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw in MEM state", 32'(state), 32'd3);
        check("sw mem_write", 32'(mem_write), 32'd1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("sw reset mem_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        model_count = 32'd0;
        check("post-reset state", 32'(state), 32'd0);
        check("post-reset count", instr_count, model_count);

        for (int n = 0; n < 200; n++) begin
            run_instr(rnd_instr(), rnd_wait(), rnd_wait(), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
